// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer, its decoder and the control core.
// Holds the instruction ID constants, the 3-bit sequencer state encoding,
// the registered strobe bundle and the counter-width helper.
package control_sequencer_pkg;

    localparam int unsigned ID_WIDTH = 7;

    typedef logic [ID_WIDTH-1:0] id_t;

    localparam id_t INSW_ID = 7'd71;
    localparam id_t SWI_ID  = 7'd72;
    localparam id_t NOP_ID  = 7'd74;
    localparam id_t HALT_ID = 7'd75;

    typedef enum logic [2:0] {
        ST_FETCH      = 3'd0,
        ST_DECODE     = 3'd1,
        ST_EXECUTE    = 3'd2,
        ST_MEMWAIT    = 3'd3,
        ST_WRITEBACK  = 3'd4,
        ST_INPUT_WAIT = 3'd5,
        ST_HALT       = 3'd6
    } state_e;

    // Datapath strobes driven towards IR, PC, register bank and memory.
    typedef struct packed {
        logic ir_load;
        logic pc_enable;
        logic rb_write_enable;
        logic mem_write_enable;
    } strobes_t;

    // Wait counter width: large enough for the longer of the two latencies.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> decoder/control-core/operator signal bundle.
// slave  : the sequencer (consumes decoded_id, mem_access and buttons, drives the rest)
// master : the surrounding logic (drives decoded_id, mem_access and buttons)
interface control_sequencer_if;

    logic [control_sequencer_pkg::ID_WIDTH-1:0] decoded_id;
    logic                                       mem_access;
    logic                                       input_confirm;
    logic                                       resume;
    logic [control_sequencer_pkg::ID_WIDTH-1:0] stage_id;
    logic                                       mode;
    logic                                       ir_load;
    logic                                       pc_enable;
    logic                                       rb_write_enable;
    logic                                       mem_write_enable;
    logic                                       waiting_input;
    logic                                       halted;

    modport slave (
        input  decoded_id, mem_access, input_confirm, resume,
        output stage_id, mode, ir_load, pc_enable, rb_write_enable,
               mem_write_enable, waiting_input, halted
    );

    modport master (
        output decoded_id, mem_access, input_confirm, resume,
        input  stage_id, mode, ir_load, pc_enable, rb_write_enable,
               mem_write_enable, waiting_input, halted
    );

endinterface

// File: rtl/control_sequencer_button_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for a raw operator button.
// Ports: clock, reset (async active-high), btn_i (raw asynchronous level),
//        pulse_c (one-cycle pulse per synchronised 0->1 transition, combinational
//        from flops only, so it carries no path from btn_i).
module control_sequencer_button_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_c
);

    logic [1:0] sync_q;
    logic       prev_q;

    // Synchroniser stages and delayed copy for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            prev_q <= sync_q[1];
        end
    end

    // A held button produces exactly one pulse.
    assign pulse_c = sync_q[1] & ~prev_q;

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXECUTE -> [MEMWAIT] -> WRITEBACK,
// with INPUT_WAIT (operator confirm) and HALT (operator resume) side states.
// Ports: clock, reset (async active-high), bus (control_sequencer_if.slave):
//   in : decoded_id, mem_access, input_confirm (raw), resume (raw)
//   out: stage_id, mode, ir_load, pc_enable, rb_write_enable, mem_write_enable,
//        waiting_input, halted -- all registered.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int unsigned FETCH_WAIT = 2,
    parameter int unsigned MEM_WAIT   = 2
) (
    input  logic                clock,
    input  logic                reset,
    control_sequencer_if.slave  bus
);

    localparam int unsigned CNT_W = cnt_width(FETCH_WAIT, MEM_WAIT);
    localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(FETCH_WAIT - 1);
    localparam logic [CNT_W-1:0] MEM_LAST   = CNT_W'(MEM_WAIT - 1);

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    id_t              stage_id_q, stage_id_d;
    logic             mode_q,    mode_d;
    strobes_t         strb_q,    strb_d;
    logic             waiting_q, waiting_d;
    logic             halted_q,  halted_d;

    logic confirm_pulse;
    logic resume_pulse;

    control_sequencer_button_edge_sync u_confirm_sync (
        .clock   (clock),
        .reset   (reset),
        .btn_i   (bus.input_confirm),
        .pulse_c (confirm_pulse)
    );

    control_sequencer_button_edge_sync u_resume_sync (
        .clock   (clock),
        .reset   (reset),
        .btn_i   (bus.resume),
        .pulse_c (resume_pulse)
    );

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            cnt_q      <= '0;
            stage_id_q <= NOP_ID;
            mode_q     <= 1'b1;
            strb_q     <= '0;
            waiting_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stage_id_q <= stage_id_d;
            mode_q     <= mode_d;
            strb_q     <= strb_d;
            waiting_q  <= waiting_d;
            halted_q   <= halted_d;
        end
    end

    // Next state, then outputs decoded from the state being entered so they
    // line up with it once registered.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stage_id_d = stage_id_q;
        mode_d     = mode_q;
        strb_d     = '0;
        waiting_d  = 1'b0;
        halted_d   = 1'b0;

        case (state_q)
            ST_FETCH: begin
                // Leave once the ir_load pulse has been presented for a cycle;
                // until then count up to the last fetch cycle and hold there.
                if (strb_q.ir_load) begin
                    state_d = ST_DECODE;
                    cnt_d   = '0;
                end else if (cnt_q < FETCH_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                stage_id_d = bus.decoded_id;
                if (bus.decoded_id == HALT_ID) begin
                    state_d = ST_HALT;
                end else if (bus.decoded_id == INSW_ID) begin
                    state_d = ST_INPUT_WAIT;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                // The core sees the old mode during EXECUTE; the toggle lands on exit.
                if (stage_id_q == SWI_ID) begin
                    mode_d = ~mode_q;
                end
                state_d = bus.mem_access ? ST_MEMWAIT : ST_WRITEBACK;
            end
            ST_MEMWAIT: begin
                if (cnt_q == MEM_LAST) begin
                    state_d = ST_WRITEBACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WRITEBACK: begin
                stage_id_d = NOP_ID;
                state_d    = ST_FETCH;
                cnt_d      = '0;
            end
            ST_INPUT_WAIT: begin
                if (confirm_pulse) begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_HALT: begin
                if (resume_pulse) begin
                    state_d = ST_WRITEBACK;
                end
            end
            default: begin
                state_d    = ST_FETCH;
                cnt_d      = '0;
                stage_id_d = NOP_ID;
            end
        endcase

        strb_d.ir_load          = (state_d == ST_FETCH) && (cnt_d == FETCH_LAST);
        strb_d.pc_enable        = (state_d == ST_WRITEBACK);
        // NOP and a resumed HALT have no result to write back.
        strb_d.rb_write_enable  = (state_d == ST_WRITEBACK) &&
                                  (stage_id_d != NOP_ID) && (stage_id_d != HALT_ID);
        strb_d.mem_write_enable = (state_d == ST_EXECUTE) || (state_d == ST_MEMWAIT);
        waiting_d               = (state_d == ST_INPUT_WAIT);
        halted_d                = (state_d == ST_HALT);
    end

    assign bus.stage_id         = stage_id_q;
    assign bus.mode             = mode_q;
    assign bus.ir_load          = strb_q.ir_load;
    assign bus.pc_enable        = strb_q.pc_enable;
    assign bus.rb_write_enable  = strb_q.rb_write_enable;
    assign bus.mem_write_enable = strb_q.mem_write_enable;
    assign bus.waiting_input    = waiting_q;
    assign bus.halted           = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios followed by a
// randomized instruction stream, each checked cycle by cycle against an
// instruction-level timeline model.
module tb_control_sequencer;
    import control_sequencer_pkg::*;

    localparam int unsigned FW = 2;
    localparam int unsigned MW = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    control_sequencer_if bus ();

    control_sequencer #(
        .FETCH_WAIT (FW),
        .MEM_WAIT   (MW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [6:0] stage;
        logic       mode;
        logic       ir;
        logic       pc;
        logic       rb;
        logic       mwe;
        logic       wi;
        logic       hlt;
    } obs_t;

    int n_checks  = 0;
    int n_errors  = 0;
    bit mode_m    = 1'b1;
    int conf_hold = 0;
    int res_hold  = 0;

    // Idle expectation: no strobes, given stage id, current model mode.
    function automatic obs_t blank(input logic [6:0] st);
        obs_t e;
        e       = '0;
        e.stage = st;
        e.mode  = mode_m;
        return e;
    endfunction

    task automatic check(input string tag, input obs_t exp);
        obs_t act;
        act = '{bus.stage_id, bus.mode, bus.ir_load, bus.pc_enable, bus.rb_write_enable,
                bus.mem_write_enable, bus.waiting_input, bus.halted};
        n_checks++;
        assert (act === exp) else begin
            n_errors++;
            $error("FAIL %s: observed stage=%0d mode=%b ir=%b pc=%b rb=%b mwe=%b wi=%b halt=%b expected stage=%0d mode=%b ir=%b pc=%b rb=%b mwe=%b wi=%b halt=%b",
                   tag, act.stage, act.mode, act.ir, act.pc, act.rb, act.mwe, act.wi, act.hlt,
                   exp.stage, exp.mode, exp.ir, exp.pc, exp.rb, exp.mwe, exp.wi, exp.hlt);
        end
    endtask

    // Advance one cycle, releasing buttons whose hold time has run out.
    task automatic step();
        if (conf_hold > 0) begin
            conf_hold--;
            if (conf_hold == 0) bus.input_confirm = 1'b0;
        end
        if (res_hold > 0) begin
            res_hold--;
            if (res_hold == 0) bus.resume = 1'b0;
        end
        @(negedge clock);
    endtask

    task automatic press(input bit is_confirm, input int hold);
        if (is_confirm) begin
            bus.input_confirm = 1'b1;
            conf_hold         = hold;
        end else begin
            bus.resume = 1'b1;
            res_hold   = hold;
        end
    endtask

    // One instruction, starting at the first fetch cycle. Button presses are
    // seen three cycles later (two sync flops plus edge detect).
    task automatic run_instr(input logic [6:0] id, input bit mem, input int wait_n,
                             input bit fetch_press, input bit abort_mw, input bit both);
        obs_t e;
        bit   is_insw;
        is_insw        = (id == INSW_ID);
        bus.decoded_id = id;
        bus.mem_access = mem;

        for (int i = 0; i < int'(FW); i++) begin
            e    = blank(NOP_ID);
            e.ir = (i == int'(FW) - 1);
            check("fetch", e);
            if (fetch_press && i == 0) press(1'b1, 2);
            step();
        end
        check("decode", blank(NOP_ID));
        step();

        if (id == HALT_ID || is_insw) begin
            e = blank(id);
            if (is_insw) e.wi = 1'b1;
            else         e.hlt = 1'b1;
            for (int i = 0; i < wait_n; i++) begin
                check(is_insw ? "input_wait" : "halt_wait", e);
                if (i == 0) press(!is_insw, 3);
                if (i == wait_n - 1) begin
                    press(is_insw, 10);
                    if (both) press(!is_insw, 10);
                end
                step();
            end
            for (int i = 0; i < 2; i++) begin
                check(is_insw ? "input_wait_sync" : "halt_wait_sync", e);
                step();
            end
            e    = blank(id);
            e.pc = 1'b1;
            e.rb = is_insw;
            check(is_insw ? "insw_writeback" : "halt_writeback", e);
            step();
        end else begin
            e     = blank(id);
            e.mwe = 1'b1;
            check("execute", e);
            if (id == SWI_ID) mode_m = ~mode_m;
            step();
            if (mem) begin
                for (int i = 0; i < int'(MW); i++) begin
                    e     = blank(id);
                    e.mwe = 1'b1;
                    check("memwait", e);
                    if (abort_mw && i == 0) begin
                        #2 reset = 1'b1;
                        #1;
                        mode_m = 1'b1;
                        check("reset_async", blank(NOP_ID));
                        @(negedge clock);
                        check("reset_held", blank(NOP_ID));
                        reset = 1'b0;
                        #1;
                        check("reset_release", blank(NOP_ID));
                        return;
                    end
                    step();
                end
            end
            e    = blank(id);
            e.pc = 1'b1;
            e.rb = (id != NOP_ID);
            check("writeback", e);
            step();
        end
    endtask

    initial begin
        logic [6:0] rid;
        bit         rmem;
        int         kind;

        bus.decoded_id    = 7'd0;
        bus.mem_access    = 1'b0;
        bus.input_confirm = 1'b0;
        bus.resume        = 1'b0;

        @(negedge clock);
        check("reset_state", blank(NOP_ID));
        @(negedge clock);
        check("reset_state_held", blank(NOP_ID));
        reset = 1'b0;

        run_instr(7'd4,  1'b0, 0,  1'b0, 1'b0, 1'b0);   // ALU op
        run_instr(7'd40, 1'b1, 0,  1'b0, 1'b0, 1'b0);   // store
        run_instr(INSW_ID, 1'b0, 20, 1'b0, 1'b0, 1'b0); // input, confirm held 10
        run_instr(7'd4,  1'b0, 0,  1'b0, 1'b0, 1'b0);
        run_instr(7'd5,  1'b1, 0,  1'b0, 1'b0, 1'b0);
        run_instr(INSW_ID, 1'b0, 8, 1'b1, 1'b0, 1'b0);  // press during fetch ignored
        run_instr(SWI_ID, 1'b0, 0, 1'b0, 1'b0, 1'b0);   // mode 1 -> 0
        run_instr(SWI_ID, 1'b0, 0, 1'b0, 1'b0, 1'b0);   // mode 0 -> 1
        run_instr(HALT_ID, 1'b0, 50, 1'b0, 1'b0, 1'b1); // halt, both buttons at once
        run_instr(NOP_ID, 1'b0, 0, 1'b0, 1'b0, 1'b0);   // NOP writes nothing
        run_instr(INSW_ID, 1'b0, 9, 1'b0, 1'b0, 1'b1);  // input, both buttons at once
        run_instr(SWI_ID, 1'b1, 0, 1'b0, 1'b0, 1'b0);   // mode -> 0
        run_instr(7'd40, 1'b1, 0, 1'b0, 1'b1, 1'b0);    // reset during MEMWAIT

        for (int n = 0; n < 30; n++) begin
            kind = int'($urandom_range(0, 9));
            rmem = 1'($urandom_range(0, 1));
            if (kind == 0)      rid = INSW_ID;
            else if (kind == 1) rid = HALT_ID;
            else if (kind == 2) rid = SWI_ID;
            else begin
                do rid = 7'($urandom_range(0, 127));
                while (rid == INSW_ID || rid == SWI_ID || rid == HALT_ID);
            end
            run_instr(rid, rmem, int'($urandom_range(8, 14)), 1'b0, 1'b0,
                      1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
